// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

   // Default operand / sum width
   localparam int SA_N = 8;

   // Controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/fa_cell.sv
// Single-bit combinational full adder used as the serial adder's arithmetic core.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);

endmodule : fa_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: feeds one operand bit pair per clock (LSB first)
// through a full-adder cell, with the cell carry registered and fed back.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int N = SA_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int            CW   = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t          r_state;
   logic [N-1:0]    r_a_sh;
   logic [N-1:0]    r_b_sh;
   logic [N-1:0]    r_sum;
   logic [CW-1:0]   r_cnt;
   logic            r_carry;
   logic            r_cout;
   logic            r_busy;
   logic            r_done;

   logic            w_s;
   logic            w_co;
   logic            w_accept;

   // A request is only honoured when no addition is in flight
   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

   fa_cell u_fa (
      .a  (r_a_sh[0]),
      .b  (r_b_sh[0]),
      .c  (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // Control FSM, carry flop, bit counter and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_state <= SHIFT;
            r_busy  <= 1'b1;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
         end else begin
            case (r_state)
               SHIFT: begin
                  r_sum   <= {w_s, r_sum[N-1:1]};
                  r_carry <= w_co;
                  if (r_cnt == LAST) begin
                     // Last bit pair: publish carry-out and pulse done next cycle
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_cout  <= w_co;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               DONE:    r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // Operand shift registers: loaded on accept, shifted right while adding
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a_sh <= a_in;
         r_b_sh <= b_in;
      end else if (r_state == SHIFT) begin
         r_a_sh <= {1'b0, r_a_sh[N-1:1]};
         r_b_sh <= {1'b0, r_b_sh[N-1:1]};
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule : serial_adder_ctrl
